sram_weight_rmw: RTL

- Read-modify-write engine sitting directly upstream of the banked synaptic weight SRAM; it is the sole master of that SRAM during learning.
- Accepts STDP weight-update requests (word address, lane, signed delta) over a valid/ready handshake.
- For each request it reads the packed weight word, applies a saturating signed add to one lane, and writes the word back.
- Reports the updated weight to the learning controller.

---
 rtl/sram_weight_rmw.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sram_weight_rmw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_weight_rmw: read-modify-write engine applying saturating signed     |
// | STDP deltas to one packed weight lane of the synaptic weight SRAM.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_weight_rmw #(
  parameter int DATA_WIDTH  = 32,
  parameter int WEIGHT_W    = 8,
  parameter int LANES       = 4,
  parameter int DELTA_W     = 8,
  parameter int TOTAL_DEPTH = 12544,
  parameter int ADDR_W      = $clog2(TOTAL_DEPTH),
  parameter int LANE_W      = ($clog2(LANES) > 0) ? $clog2(LANES) : 1
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LANE_W-1:0]     req_lane,
  input  logic [DELTA_W-1:0]    req_delta,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  upd_done,
  output logic [WEIGHT_W-1:0]   upd_weight,
  output logic                  upd_sat,
  output logic                  upd_err,
  output logic                  busy
);

  localparam int SUM_W = ((WEIGHT_W > DELTA_W) ? WEIGHT_W : DELTA_W) + 1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(TOTAL_DEPTH);
  localparam logic signed [SUM_W-1:0] c_wmax = SUM_W'((1 << (WEIGHT_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] c_wmin = SUM_W'(-(1 << (WEIGHT_W-1)));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MOD  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_cs;
  logic                    r_we;
  logic                    r_done;
  logic                    r_sat;
  logic                    r_err;
  logic [ADDR_W-1:0]       r_addr;
  logic [LANE_W-1:0]       r_lane;
  logic [DELTA_W-1:0]      r_delta;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [WEIGHT_W-1:0]     r_weight;

  logic [WEIGHT_W-1:0]     w_lane_old;
  logic signed [SUM_W-1:0] w_lane_ext;
  logic signed [SUM_W-1:0] w_delta_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic [WEIGHT_W-1:0]     w_new;
  logic                    w_sat;
  logic [DATA_WIDTH-1:0]   w_word;
  logic                    w_oor;

  assign w_oor = ({1'b0, req_addr} >= c_depth);

  always_comb begin
    w_lane_old = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == LANE_W'(k)) w_lane_old = sram_q[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Widened by one bit beyond the larger operand so the sum cannot wrap before clamping.
  assign w_lane_ext  = {{(SUM_W-WEIGHT_W){w_lane_old[WEIGHT_W-1]}}, w_lane_old};
  assign w_delta_ext = {{(SUM_W-DELTA_W){r_delta[DELTA_W-1]}}, r_delta};
  assign w_sum       = w_lane_ext + w_delta_ext;

  always_comb begin
    w_new = w_sum[WEIGHT_W-1:0];
    w_sat = 1'b0;
    if (w_sum > c_wmax) begin
      w_new = c_wmax[WEIGHT_W-1:0];
      w_sat = 1'b1;
    end else if (w_sum < c_wmin) begin
      w_new = c_wmin[WEIGHT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_comb begin
    w_word = sram_q;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == LANE_W'(k)) w_word[k*WEIGHT_W +: WEIGHT_W] = w_new;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_cs     <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_lane   <= '0;
      r_delta  <= '0;
      r_word   <= '0;
      r_weight <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_lane  <= req_lane;
            r_delta <= req_delta;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_oor) begin
              r_err    <= 1'b1;
              r_sat    <= 1'b0;
              r_weight <= '0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_cs    <= 1'b1;
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_cs    <= 1'b0;
          r_state <= S_MOD;
        end
        S_MOD: begin
          r_word   <= w_word;
          r_weight <= w_new;
          r_sat    <= w_sat;
          r_cs     <= 1'b1;
          r_we     <= 1'b1;
          r_state  <= S_WR;
        end
        S_WR: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign sram_cs    = r_cs;
  assign sram_we    = r_we;
  assign sram_a     = r_addr;
  assign sram_d     = r_word;
  assign upd_done   = r_done;
  assign upd_weight = r_weight;
  assign upd_sat    = r_sat;
  assign upd_err    = r_err;

endmodule
`default_nettype wire
